// File: rtl/rpc2_ctrl_fifo_pkg.sv
// RPC2 controller FIFO shared definitions.
// Read-mode selectors and depth helper.
package rpc2_ctrl_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_depth(input int addr_bits);
        return 1 << addr_bits;
    endfunction

endpackage

// File: rtl/rpc2_ctrl_fifo_ram.sv
// RPC2 controller FIFO storage: D x DATA_WIDTH simple dual-port RAM.
// Synchronous read for standard mode, asynchronous read for FWFT.
module rpc2_ctrl_fifo_ram
    import rpc2_ctrl_fifo_pkg::*;
#(
    parameter int ADDR_BITS  = 9,
    parameter int DATA_WIDTH = 16,
    parameter int RD_MODE    = FIFO_MODE_STD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int D = fifo_depth(ADDR_BITS);

    logic [DATA_WIDTH-1:0] mem [D];

    // Write port; array is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (RD_MODE == FIFO_MODE_STD) begin : g_sync
            logic [DATA_WIDTH-1:0] rdata_q;

            // Output register loads only on an accepted read, holds otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (re) begin
                    rdata_q <= mem[raddr];
                end
            end

            assign rdata = rdata_q;
        end else begin : g_async
            assign rdata = mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/rpc2_ctrl_sync_fifo_ex.sv
// RPC2 controller single-clock FIFO with FWFT option, fill level,
// almost-full/empty thresholds, flush and sticky error flags.
module rpc2_ctrl_sync_fifo_ex
    import rpc2_ctrl_fifo_pkg::*;
#(
    parameter int ADDR_BITS  = 9,
    parameter int DATA_WIDTH = 16,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic [ADDR_BITS:0]    level,
    input  logic [ADDR_BITS:0]    af_thresh,
    input  logic [ADDR_BITS:0]    ae_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int D = fifo_depth(ADDR_BITS);
    localparam int RD_MODE = (FWFT != 0) ? FIFO_MODE_FWFT : FIFO_MODE_STD;

    localparam logic [ADDR_BITS:0]   DEPTH_L = (ADDR_BITS+1)'(D);
    localparam logic [ADDR_BITS:0]   LVL_ONE = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [ADDR_BITS-1:0]  rd_ptr;
    logic [ADDR_BITS:0]    level_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Flags come only from the registered level, never from raw requests.
    assign empty = (level_q == '0);
    assign full  = (level_q == DEPTH_L);
    assign level = level_q;

    assign wr_acc = wr_en & ~full & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    assign almost_full  = (level_q >= af_thresh);
    assign almost_empty = (level_q <= ae_thresh);

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Pointers wrap modulo D; flush rewinds both to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Fill level: +1 on write only, -1 on read only, hold on both/neither.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else if (flush) begin
            level_q <= '0;
        end else if (wr_acc && !rd_acc) begin
            level_q <= level_q + LVL_ONE;
        end else if (rd_acc && !wr_acc) begin
            level_q <= level_q - LVL_ONE;
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (wr_en & full & ~flush)
                         | (overflow_q & ~clr_err);
            underflow_q <= (rd_en & empty & ~flush)
                         | (underflow_q & ~clr_err);
        end
    end

    rpc2_ctrl_fifo_ram #(
        .ADDR_BITS  (ADDR_BITS),
        .DATA_WIDTH (DATA_WIDTH),
        .RD_MODE    (RD_MODE)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    generate
        if (RD_MODE == FIFO_MODE_FWFT) begin : g_fwft
            // Head word shown while non-empty; forced to zero when empty.
            assign rd_data = empty ? '0 : ram_rdata;
        end else begin : g_std
            assign rd_data = ram_rdata;
        end
    endgenerate

endmodule
